// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg : shared state encoding and HD44780 command bytes for lcd_menu_seq
// Rev 1.0
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_ADR  = 3'd2,
        ST_CHR  = 3'd3,
        ST_GAP  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam logic [7:0] c_CMD_CLEAR  = 8'h01;
    localparam logic [7:0] c_LINE0_ADDR = 8'h80;
    localparam logic [7:0] c_LINE1_ADDR = 8'hC0;
    localparam logic [7:0] c_SPACE      = 8'h20;

    // Anything the LCD cannot render as a glyph is shown as a blank.
    function automatic logic [7:0] printable(input logic [7:0] ch);
        return ((ch < 8'h20) || (ch > 8'h7E)) ? c_SPACE : ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_text_rom.sv
`default_nettype none
// ============================================================================
// lcd_text_rom : combinational menu text, addressed by {page, line, col}
// Rev 1.0
// ============================================================================
module lcd_text_rom
    import lcd_pkg::*;
#(
    parameter  int N_PAGES  = 4,
    parameter  int N_LINES  = 2,
    parameter  int LINE_LEN = 16,
    localparam int PW       = (N_PAGES > 1) ? $clog2(N_PAGES) : 1,
    localparam int CW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
    input  logic [PW-1:0] i_page,
    input  logic          i_line,
    input  logic [CW-1:0] i_col,
    output logic [7:0]    o_char
);

    logic [1:0]   w_sel_page;
    logic [3:0]   w_col4;
    logic [6:0]   w_bit_lo;
    logic [127:0] w_row;
    logic [7:0]   w_raw;

    // Four stored pages; larger page counts reuse them cyclically.
    assign w_sel_page = 2'(i_page);
    assign w_col4     = 4'(i_col);
    assign w_bit_lo   = {~w_col4, 3'b000};

    always_comb begin
        w_row = {16{c_SPACE}};
        case ({w_sel_page, i_line})
            3'b000: w_row = "Clave invalida  ";
            3'b001: w_row = "Intente de nuevo";
            3'b010: w_row = "Menu principal  ";
            3'b011: w_row = "1:Config 2:Info ";
            3'b100: w_row = "Configuracion   ";
            3'b101: w_row = "Brillo: 50%     ";
            3'b110: w_row = "Acerca de LM32  ";
            3'b111: w_row = {"Ver 1.0 ", 8'h07, 8'h7F, "     ", 8'h7E};
            default: w_row = {16{c_SPACE}};
        endcase
    end

    always_comb begin
        w_raw = c_SPACE;
        if ((int'(i_col) < 16) && ((N_LINES > 1) || !i_line))
            w_raw = w_row[w_bit_lo +: 8];
    end

    assign o_char = printable(w_raw);

endmodule
`default_nettype wire

// File: rtl/lcd_menu_seq.sv
`default_nettype none
// ============================================================================
// lcd_menu_seq : redraws one menu page (clear, per-line address + text)
// Rev 1.0
// ============================================================================
module lcd_menu_seq
    import lcd_pkg::*;
#(
    parameter  int         N_PAGES    = 4,
    parameter  int         N_LINES    = 2,
    parameter  int         LINE_LEN   = 16,
    parameter  logic [7:0] CMD_CLEAR  = c_CMD_CLEAR,
    parameter  logic [7:0] LINE0_ADDR = c_LINE0_ADDR,
    parameter  logic [7:0] LINE1_ADDR = c_LINE1_ADDR,
    localparam int         PW         = (N_PAGES > 1) ? $clog2(N_PAGES) : 1,
    localparam int         CW         = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrmenu,
    input  logic          up,
    input  logic          down,
    input  logic          lcd_rdy,
    output logic [7:0]    dbi,
    output logic          wr,
    output logic [7:0]    direc,
    output logic          dr,
    output logic [PW-1:0] page,
    output logic          busy,
    output logic          done
);

    state_t        r_state;
    state_t        r_next;
    logic [PW-1:0] r_page;
    logic          r_line;
    logic [CW-1:0] r_col;
    logic          r_pending;
    logic          r_up_q;
    logic          r_dn_q;
    logic [7:0]    r_dbi;
    logic [7:0]    r_direc;
    logic          r_wr;
    logic          r_dr;
    logic          r_busy;
    logic          r_done;

    logic [7:0]    w_char;
    logic          w_up_ev;
    logic          w_dn_ev;
    logic          w_nav;
    logic          w_col_last;
    logic          w_line_last;

    // Simultaneous up and down edges cancel each other.
    assign w_up_ev     = up   & ~r_up_q & ~(down & ~r_dn_q);
    assign w_dn_ev     = down & ~r_dn_q & ~(up   & ~r_up_q);
    assign w_nav       = w_up_ev | w_dn_ev;
    assign w_col_last  = (r_col == CW'(LINE_LEN - 1));
    assign w_line_last = (N_LINES < 2) || r_line;

    lcd_text_rom #(
        .N_PAGES  (N_PAGES),
        .N_LINES  (N_LINES),
        .LINE_LEN (LINE_LEN)
    ) u_rom (
        .i_page (r_page),
        .i_line (r_line),
        .i_col  (r_col),
        .o_char (w_char)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_next    <= ST_IDLE;
            r_page    <= '0;
            r_line    <= 1'b0;
            r_col     <= '0;
            r_pending <= 1'b0;
            r_up_q    <= 1'b0;
            r_dn_q    <= 1'b0;
            r_dbi     <= '0;
            r_direc   <= '0;
            r_wr      <= 1'b0;
            r_dr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_up_q <= up;
            r_dn_q <= down;
            r_wr   <= 1'b0;
            r_dr   <= 1'b0;
            r_done <= 1'b0;

            if (w_up_ev)
                r_page <= (r_page == PW'(N_PAGES - 1)) ? '0 : r_page + 1'b1;
            else if (w_dn_ev)
                r_page <= (r_page == '0) ? PW'(N_PAGES - 1) : r_page - 1'b1;

            // Only a fresh nav event can re-arm the flag on the cycle it is consumed.
            if ((r_state == ST_IDLE) && r_pending)
                r_pending <= w_nav;
            else if (w_nav || (wrmenu && (r_state == ST_IDLE)))
                r_pending <= 1'b1;

            unique case (r_state)
                ST_IDLE: begin
                    if (r_pending)
                        r_state <= ST_CLR;
                end
                ST_CLR: begin
                    if (lcd_rdy) begin
                        r_dr    <= 1'b1;
                        r_direc <= CMD_CLEAR;
                        r_busy  <= 1'b1;
                        r_line  <= 1'b0;
                        r_next  <= ST_ADR;
                        r_state <= ST_GAP;
                    end
                end
                ST_ADR: begin
                    if (lcd_rdy) begin
                        r_dr    <= 1'b1;
                        r_direc <= r_line ? LINE1_ADDR : LINE0_ADDR;
                        r_col   <= '0;
                        r_next  <= ST_CHR;
                        r_state <= ST_GAP;
                    end
                end
                ST_CHR: begin
                    // Advance position now so the GAP cycle only has to dispatch.
                    if (lcd_rdy) begin
                        r_wr    <= 1'b1;
                        r_dbi   <= w_char;
                        r_state <= ST_GAP;
                        if (!w_col_last) begin
                            r_col  <= r_col + 1'b1;
                            r_next <= ST_CHR;
                        end else if (!w_line_last) begin
                            r_line <= 1'b1;
                            r_next <= ST_ADR;
                        end else begin
                            r_next <= ST_FIN;
                        end
                    end
                end
                ST_GAP: begin
                    r_state <= r_next;
                    if (r_next == ST_FIN) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbi   = r_dbi;
    assign wr    = r_wr;
    assign direc = r_direc;
    assign dr    = r_dr;
    assign page  = r_page;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: doc/lcd_menu_seq.md
Name: lcd_menu_seq

Overview:
- Parametrised menu-page sequencer for the character LCD on the LM32 wb_lcd path.
- On a start request or an up/down navigation event, it redraws one text page: a clear command, then for each line a DDRAM address command followed by LINE_LEN characters.
- Page text comes from the sub-module lcd_text_rom.
- Outputs drive the existing LCD write controller through dbi/wr and direc/dr, throttled by a ready handshake.

Parameters:
- N_PAGES, 4: number of menu pages; page index width PW = clog2(N_PAGES), minimum 1.
- N_LINES, 2: lines per page, legal values 1 or 2.
- LINE_LEN, 16: characters per line.
- CMD_CLEAR, 8'h01: clear-display command.
- LINE0_ADDR, 8'h80: set-DDRAM command for line 0.
- LINE1_ADDR, 8'hC0: set-DDRAM command for line 1.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- wrmenu  in  1  level request to draw the current page.
- up  in  1  next page, acted on at its rising edge.
- down  in  1  previous page, acted on at its rising edge.
- lcd_rdy  in  1  LCD controller can accept a strobe this cycle.
- dbi  out  8  character data, valid while wr=1.
- wr  out  1  one-cycle character-write strobe.
- direc  out  8  command byte, valid while dr=1.
- dr  out  1  one-cycle command strobe.
- page  out  PW  currently displayed or selected page.
- busy  out  1  high from the first strobe until draw completion.
- done  out  1  one-cycle pulse when a draw completes.

Behaviour:
- Reset (rst=0, async): state IDLE; page=0; dbi=0, direc=0; wr=dr=busy=done=0; pending flag and edge-detect registers cleared.
- Edge detection: up and down are registered once; an event is input high and previous value low.
  - up and down events in the same cycle: both ignored.
- Page update happens in the event cycle, with wrap-around:
  - up: page = page+1, and N_PAGES-1 wraps to 0.
  - down: page = page-1, and 0 wraps to N_PAGES-1.
- Request sources and pending flag:
  - A nav event sets the pending flag. A nav event while busy still updates page, and the redraw shows the final page.
  - wrmenu=1 in IDLE sets the pending flag; wrmenu is ignored while busy.
  - Multiple requests during a draw collapse to one redraw.
- FSM states and transitions:
  - IDLE: pending flag set -> CLR; flag cleared on entry to CLR.
  - CLR: when lcd_rdy=1, drive dr=1, direc=CMD_CLEAR for one cycle -> GAP (next=ADR, line=0).
  - ADR: when lcd_rdy=1, drive dr=1, direc = line ? LINE1_ADDR : LINE0_ADDR -> GAP (next=CHR, col=0).
  - CHR: when lcd_rdy=1, drive wr=1, dbi = rom[page][line][col] -> GAP.
  - GAP advance rules:
    - col<LINE_LEN-1: col++, go to CHR.
    - Else, line<N_LINES-1: line++, go to ADR.
    - Else: go to FIN.
  - GAP lasts exactly one cycle and never strobes. It guarantees wr/dr are never high on consecutive cycles.
  - FIN: done=1 for one cycle -> IDLE.
- Strobe rules:
  - While lcd_rdy=0, the FSM holds its state and no strobe is issued.
  - wr and dr are never high together.
  - dbi and direc hold their last value when not strobing.
- busy:
  - Rises in the cycle the CLR strobe is issued.
  - Falls in the cycle done pulses.
- Draw size and latency:
  - Strobe count per draw = 1 + N_LINES*(1+LINE_LEN), which is 35 for the defaults.
  - With lcd_rdy held at 1, latency from CLR entry to done = 2*35 cycles.
- ROM interface: combinational, address {page, line, col}.
  - Characters outside 0x20..0x7E are replaced by 0x20 before output.
- Reset mid-draw: immediate abort; no further strobes; page returns to 0.

Decomposition:
- Package lcd_pkg holds:
  - FSM state encoding (IDLE, CLR, ADR, CHR, GAP, FIN).
  - HD44780 command constants (CMD_CLEAR, LINE0_ADDR, LINE1_ADDR).
  - Space character 8'h20.
- Sub-module lcd_text_rom:
  - Parameters N_PAGES, N_LINES, LINE_LEN.
  - Inputs page, line, col; output 8-bit char.
  - Page 0 line 0 holds "Contrasena invalida"-style menu text, space-padded.

Test Plan:
- Reset, then wrmenu pulse with lcd_rdy=1:
  - Expect dr/01, dr/80, 16 wr characters, dr/C0, 16 wr characters.
  - Exactly 35 strobes, done at cycle 70, busy low afterwards, page=0.
- lcd_rdy toggled pseudo-randomly during a draw:
  - Strobes occur only when lcd_rdy=1.
  - Sequence identical to the previous case; no back-to-back strobes; wr&dr never both 1.
- page=3: up rising edge gives page=0 and a redraw of page 0. Then a down edge gives page=3 and a redraw of page 3.
- up and down rising in the same cycle: page unchanged, no draw started, busy stays 0.
- Two up edges during a draw from page 0:
  - page=2 by the end of the draw.
  - Exactly one further draw, of page 2, follows done.
- rst asserted low after the 10th strobe:
  - Outputs go 0 asynchronously and page=0.
  - No strobes until the next wrmenu.
